// File: rtl/rasterizer_scheduler.sv
// -----------------------------------------------------------------------------
// rasterizer_scheduler
//
// Accepts triangle setup words from the setup stage and dispatches them, one
// at a time, to a single rasterizer backend. Words are buffered in a 2-entry
// FIFO. Each triangle goes through ISSUE -> START -> GUARD -> RUN. START
// produces a one-cycle be_start pulse. Integration uses ~be_start as the
// backend's rstn, so that pulse also restarts the backend. GUARD ignores the
// backend's done level for one cycle, because that level is still stale from
// the previous triangle while the backend runs its STAGE1 cycle. When the
// triangle that carries in_last completes, the block emits frame_done and
// publishes how many triangles the frame contained.
//
// Ports
//   clk             in   single clock, rising edge
//   rst             in   synchronous active-high reset
//   in_valid        in   setup word offered
//   in_ready        out  word accepted this cycle (FIFO not full)
//   in_data         in   PAYLOAD_WIDTH opaque setup word
//   in_last         in   word is the final triangle of its frame
//   be_start        out  one-cycle backend launch pulse
//   be_payload      out  setup word held stable for the running backend
//   be_done         in   backend done level
//   busy            out  high whenever the FSM is not IDLE
//   frame_done      out  one-cycle pulse once a frame's last triangle is done
//   frame_tri_count out  triangles completed in the last finished frame
// -----------------------------------------------------------------------------
module rasterizer_scheduler #(
  parameter int PAYLOAD_WIDTH = 176,
  parameter int COUNT_WIDTH   = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_WIDTH-1:0] in_data,
  input  logic                     in_last,
  output logic                     be_start,
  output logic [PAYLOAD_WIDTH-1:0] be_payload,
  input  logic                     be_done,
  output logic                     busy,
  output logic                     frame_done,
  output logic [COUNT_WIDTH-1:0]   frame_tri_count
);

  localparam int ENTRY_W = PAYLOAD_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    START,
    GUARD,
    RUN,
    FRAME_DONE
  } state_t;

  state_t state, state_d;

  // ---------------------------------------------------------------------------
  // 2-entry input FIFO, entry = {last, data}
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         occ;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;

  // in_ready comes from registered occupancy only, so the upstream handshake
  // has no combinational path through the FSM.
  assign in_ready   = (occ < 2'd2);
  assign fifo_empty = (occ == 2'd0);
  assign push       = in_valid && in_ready;
  // The FSM only reaches ISSUE with a word available; the occupancy term
  // keeps the pointers safe even so.
  assign pop        = (state == ISSUE) && !fifo_empty;
  assign fifo_head  = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      // NOTE: sequential state is always assigned with <=, so every flop
      // samples pre-edge values regardless of statement order.
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      // A push and a pop in the same cycle leave occupancy unchanged.
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy alone says which entries
  // are valid, so clearing 2 x 177 flops would buy nothing.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_last, in_data};
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic                   active_last;
  logic [COUNT_WIDTH-1:0] run_count;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    // NOTE: the default comes first, so a path that forgets to assign
    // state_d cannot infer a latch.
    state_d = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_d = ISSUE;
      end
      ISSUE: state_d = START;
      START: state_d = GUARD;
      // be_done still holds the previous triangle's level here.
      GUARD: state_d = RUN;
      RUN: begin
        if (be_done) begin
          if (active_last)      state_d = FRAME_DONE;
          else if (!fifo_empty) state_d = ISSUE;
          else                  state_d = IDLE;
        end
      end
      FRAME_DONE: begin
        if (!fifo_empty) state_d = ISSUE;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Active triangle, counters and registered status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      be_payload      <= '0;
      active_last     <= 1'b0;
      run_count       <= '0;
      frame_tri_count <= '0;
      be_start        <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      // Outputs are decoded from the next state and registered. They line up
      // exactly with the state they describe, and the backend rstn (~be_start)
      // comes straight from a flop.
      be_start   <= (state_d == START);
      busy       <= (state_d != IDLE);
      frame_done <= (state_d == FRAME_DONE);

      // be_payload is loaded only here, so it stays stable from START until
      // the triangle completes.
      if (state == ISSUE) begin
        {active_last, be_payload} <= fifo_head;
      end

      // Counts completions. It wraps silently, modulo 2^COUNT_WIDTH.
      if ((state == RUN) && be_done) begin
        run_count <= run_count + COUNT_WIDTH'(1);
      end

      // The last triangle was already counted on the way out of RUN.
      if (state == FRAME_DONE) begin
        frame_tri_count <= run_count;
        run_count       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rasterizer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rasterizer_scheduler
//
// Directed scenarios followed by a randomized phase. A transaction-level
// reference model checks the design: a queue of accepted words gives the
// expected dispatch order, and frame sizes are counted as triangles issued
// between in_last markers. A small behavioural backend returns be_done a
// programmable number of cycles after each be_start. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_rasterizer_scheduler;

  localparam int PW = 176;
  localparam int CW = 4;     // narrow counter so the wrap case is cheap to reach

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          in_last;
  logic          be_start;
  logic [PW-1:0] be_payload;
  logic          be_done;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] frame_tri_count;

  always #5 clk = ~clk;

  rasterizer_scheduler #(
    .PAYLOAD_WIDTH (PW),
    .COUNT_WIDTH   (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_last         (in_last),
    .be_start        (be_start),
    .be_payload      (be_payload),
    .be_done         (be_done),
    .busy            (busy),
    .frame_done      (frame_done),
    .frame_tri_count (frame_tri_count)
  );

  // Backend: be_start restarts it. be_done goes high be_lat+1 cycles after
  // the be_start cycle and stays high until the next launch. 'stale' forces
  // the done level high independently.
  int   be_lat;
  int   be_cnt;
  logic be_done_r;
  logic stale;

  always @(posedge clk) begin
    if (rst) begin
      be_cnt    <= 0;
      be_done_r <= 1'b0;
    end else if (be_start) begin
      be_cnt    <= be_lat;
      be_done_r <= 1'b0;
    end else if (be_cnt != 0) begin
      be_cnt <= be_cnt - 1;
      if (be_cnt == 1) be_done_r <= 1'b1;
    end
  end

  assign be_done = be_done_r | stale;

  // Reference model and bookkeeping
  logic [PW:0] acc_q[$];      // accepted, not yet dispatched: {last, data}
  int          exp_ftc_q[$];  // frame sizes whose last triangle has dispatched
  int          tri_in_frame;
  int          starts_seen;
  int          frames_seen;
  int          cyc;
  int          pending_ftc;
  bit          ftc_due;
  int          pass_cnt;
  int          fail_cnt;
  int          check_cnt;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    check_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [PW-1:0] rand_word();
    logic [191:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return w[PW-1:0];
  endfunction

  // One clock cycle. It records an acceptance using the handshake as it
  // stands before the edge, then checks outputs at the following falling edge.
  task automatic tick(output bit acc);
    logic [PW:0] head;
    acc = in_valid && in_ready;
    if (acc) acc_q.push_back({in_last, in_data});
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (ftc_due) begin
      check("frame_tri_count", frame_tri_count, pending_ftc);
      ftc_due = 1'b0;
    end
    if (be_start) begin
      starts_seen++;
      check("start_has_work", acc_q.size() != 0, 1);
      if (acc_q.size() != 0) begin
        head = acc_q.pop_front();
        check("be_payload_order", be_payload, head[PW-1:0]);
        tri_in_frame++;
        if (head[PW]) begin
          exp_ftc_q.push_back(tri_in_frame % (1 << CW));
          tri_in_frame = 0;
        end
      end
    end
    if (frame_done) begin
      frames_seen++;
      check("frame_done_expected", exp_ftc_q.size() != 0, 1);
      if (exp_ftc_q.size() != 0) begin
        pending_ftc = exp_ftc_q.pop_front();
        ftc_due     = 1'b1;
      end
    end
  endtask

  task automatic push(input logic [PW-1:0] d, input logic l);
    bit acc;
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 200);
    check("push_accepted", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_frame(input int target, input int limit);
    bit acc;
    int n;
    n = 0;
    while (frames_seen < target && n < limit) begin
      tick(acc);
      n++;
    end
    check("frame_done_timeout", frames_seen >= target, 1);
    tick(acc);  // lets the model compare frame_tri_count
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            acc;
    int            n;
    int            push_cyc;
    int            start_cyc;
    int            done_cyc;
    int            fd_cyc;
    int            base;
    logic [PW-1:0] w;

    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_last      = 1'b0;
    stale        = 1'b0;
    be_lat       = 9;
    tri_in_frame = 0;
    starts_seen  = 0;
    frames_seen  = 0;
    cyc          = 0;
    pending_ftc  = 0;
    ftc_due      = 1'b0;
    pass_cnt     = 0;
    fail_cnt     = 0;
    check_cnt    = 0;

    // ---- Reset state
    repeat (3) tick(acc);
    check("reset_in_ready",   in_ready, 1);
    check("reset_busy",       busy, 0);
    check("reset_be_start",   be_start, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_ftc",        frame_tri_count, 0);
    check("reset_payload",    be_payload, 0);
    rst = 1'b0;
    tick(acc);

    // ---- Single-triangle frame, backend done 10 cycles after be_start
    push(rand_word(), 1'b1);
    push_cyc = cyc;
    n = 0;
    while (!be_start && n < 20) begin tick(acc); n++; end
    start_cyc = cyc;
    check("t1_start_latency", start_cyc - push_cyc, 2);
    check("t1_busy", busy, 1);
    done_cyc = -1;
    n = 0;
    while (!frame_done && n < 50) begin
      tick(acc);
      if (be_done && done_cyc < 0) done_cyc = cyc;
      n++;
    end
    fd_cyc = cyc;
    check("t1_done_to_frame_done", fd_cyc - done_cyc, 1);
    check("t1_start_to_frame_done", fd_cyc - start_cyc, 11);
    tick(acc);
    check("t1_idle_busy", busy, 0);

    // ---- Stale done held high through IDLE/ISSUE/START/GUARD
    stale = 1'b1;
    repeat (2) tick(acc);
    check("t2_idle_ignores_done", busy, 0);
    push(rand_word(), 1'b1);
    n = 0;
    while (!be_start && n < 20) begin tick(acc); n++; end
    start_cyc = cyc;
    tick(acc);                  // GUARD, done still forced high
    check("t2_no_early_done", frame_done, 0);
    tick(acc);                  // now in RUN
    stale = 1'b0;
    n = 0;
    while (!frame_done && n < 50) begin tick(acc); n++; end
    check("t2_start_to_frame_done", cyc - start_cyc, 11);
    tick(acc);

    // ---- Back-pressure: A,B,C back to back with a slow backend; frame of 3
    be_lat = 12;
    base = frames_seen;
    push(rand_word(), 1'b0);
    push(rand_word(), 1'b0);
    push(rand_word(), 1'b1);
    check("t3_full_in_ready", in_ready, 0);
    repeat (3) tick(acc);
    check("t3_still_full", in_ready, 0);
    wait_frame(base + 1, 300);

    // ---- Following frame of 2
    be_lat = 3;
    base = frames_seen;
    push(rand_word(), 1'b0);
    push(rand_word(), 1'b1);
    wait_frame(base + 1, 200);

    // ---- Push/pop in ISSUE at occupancy 1, then ISSUE at occupancy 2
    be_lat = 8;
    base = frames_seen;
    push(rand_word(), 1'b0);    // X, FSM still IDLE
    tick(acc);                  // FSM now in ISSUE with one word
    in_valid = 1'b1; in_data = rand_word(); in_last = 1'b0;
    tick(acc);                  // Y pushed while X pops
    check("t4_push_in_issue", acc, 1);
    check("t4_occ_stays_1", in_ready, 1);
    in_data = rand_word();
    tick(acc);                  // Z fills the FIFO
    check("t4_push_z", acc, 1);
    check("t4_full", in_ready, 0);
    in_data = rand_word(); in_last = 1'b1;   // W waits through ISSUE at occupancy 2
    n = 0;
    do begin tick(acc); n++; end while (!acc && n < 200);
    check("t4_push_w", acc, 1);
    in_valid = 1'b0;
    wait_frame(base + 1, 300);

    // ---- Counter wrap: 17 triangles in one frame with a 4-bit counter
    be_lat = 1;
    base = frames_seen;
    for (int i = 0; i < 17; i++) push(rand_word(), (i == 16));
    wait_frame(base + 1, 400);

    // ---- Randomized traffic, random latency and random stale done pulses
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = rand_word();
      in_last  = ($urandom_range(0, 3) == 0);
      be_lat   = $urandom_range(1, 8);
      stale    = ($urandom_range(0, 7) == 0);
      tick(acc);
    end
    in_valid = 1'b0;
    stale    = 1'b0;
    be_lat   = 2;
    push(rand_word(), 1'b1);
    n = 0;
    while ((acc_q.size() != 0 || exp_ftc_q.size() != 0 || ftc_due) && n < 3000) begin
      tick(acc);
      n++;
    end
    check("t6_drained", (acc_q.size() == 0) && (exp_ftc_q.size() == 0), 1);
    tick(acc);

    // ---- Reset during RUN with two words buffered and one triangle counted
    be_lat = 3;
    base = starts_seen;
    push(rand_word(), 1'b0);    // P, completes before the reset
    push(rand_word(), 1'b0);    // Q, running when the reset hits
    push(rand_word(), 1'b0);    // R
    be_lat = 30;
    push(rand_word(), 1'b1);    // S
    n = 0;
    while (starts_seen < base + 2 && n < 100) begin tick(acc); n++; end
    repeat (3) tick(acc);
    check("t7_prereset_busy", busy, 1);
    check("t7_prereset_full", in_ready, 0);
    rst = 1'b1;
    tick(acc);
    check("t7_in_ready",   in_ready, 1);
    check("t7_busy",       busy, 0);
    check("t7_be_start",   be_start, 0);
    check("t7_frame_done", frame_done, 0);
    check("t7_ftc",        frame_tri_count, 0);
    rst = 1'b0;
    acc_q.delete();
    exp_ftc_q.delete();
    tri_in_frame = 0;
    ftc_due      = 1'b0;
    base = frames_seen;
    repeat (40) tick(acc);
    check("t7_no_frame_done_after_reset", frames_seen, base);
    be_lat = 4;
    push(rand_word(), 1'b0);
    push(rand_word(), 1'b1);
    wait_frame(base + 1, 200);

    check("all_frames_accounted", exp_ftc_q.size() == 0, 1);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
